// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined 3:2 carry-save reduction tree with elastic
// valid/ready stages. It reduces PP_NUM shifted, sign-extended partial
// products to one redundant sum/carry pair, mod 2^OUT_WIDTH.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous clear of all valid bits (wins over handshake)
//   in_valid/in_ready   input handshake
//   in_pp               PP_NUM partial products, pp i at [i*PP_WIDTH +: PP_WIDTH]
//   in_tag              sideband, returned unchanged with the result
//   out_valid/out_ready output handshake
//   out_sum/out_carry   redundant result pair (carry already weight-aligned)
//   out_tag             tag of the result beat
//   out_product         out_sum + out_carry, present only with CSA_TREE_CPA_EN
//
// Build option: define CSA_TREE_CPA_EN to append one registered
// carry-propagate stage that drives out_product (latency STAGES+1).

module csa_tree_pipe #(
  parameter int unsigned PP_NUM    = 13,
  parameter int unsigned PP_WIDTH  = 26,
  parameter int unsigned PP_SHIFT  = 2,
  parameter int unsigned OUT_WIDTH = 52,
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PP_NUM*PP_WIDTH-1:0]   in_pp,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_sum,
  output logic [OUT_WIDTH-1:0]         out_carry,
  output logic [TAG_W-1:0]             out_tag
`ifdef CSA_TREE_CPA_EN
  ,
  output logic [OUT_WIDTH-1:0]         out_product
`endif
);

  // Row count entering level lvl under greedy Wallace grouping.
  function automatic int unsigned rows_at(int unsigned lvl);
    int unsigned n;
    n = PP_NUM;
    for (int unsigned i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  // Number of CSA levels needed to reach two rows.
  function automatic int unsigned count_levels();
    int unsigned n;
    int unsigned c;
    n = PP_NUM;
    c = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      c++;
    end
    return c;
  endfunction

  localparam int unsigned LEVELS = count_levels();
  localparam int unsigned STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  logic [OUT_WIDTH-1:0] w_align [PP_NUM];
  logic                 w_tail_rdy;

  // Sign-extend each pp to the result width, then weight it by 2^(i*PP_SHIFT).
  for (genvar i = 0; i < PP_NUM; i++) begin : g_align
    assign w_align[i] = OUT_WIDTH'($signed(in_pp[i*PP_WIDTH +: PP_WIDTH])) << (i * PP_SHIFT);
  end

  // CSA levels. A level's input comes from the previous level, or from a
  // stage register when a pipeline boundary falls in front of it.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned N  = rows_at(l);
    localparam int unsigned NC = N / 3;
    logic [OUT_WIDTH-1:0] w_in  [PP_NUM];
    logic [OUT_WIDTH-1:0] w_out [PP_NUM];
    for (genvar j = 0; j < PP_NUM; j++) begin : g_row
      if (l == 0) begin : g_src_in
        assign w_in[j] = w_align[j];
      end else if (l % REG_EVERY == 0) begin : g_src_reg
        assign w_in[j] = g_stg[l/REG_EVERY-1].r_data[j];
      end else begin : g_src_comb
        assign w_in[j] = g_lvl[l-1].w_out[j];
      end

      if (j < 2 * NC) begin : g_csa
        if (j % 2 == 0) begin : g_sum
          assign w_out[j] = w_in[3*(j/2)] ^ w_in[3*(j/2)+1] ^ w_in[3*(j/2)+2];
        end else begin : g_carry
          // Majority moves up one weight; the bit leaving the top is dropped.
          assign w_out[j] = ((w_in[3*(j/2)]   & w_in[3*(j/2)+1]) |
                             (w_in[3*(j/2)]   & w_in[3*(j/2)+2]) |
                             (w_in[3*(j/2)+1] & w_in[3*(j/2)+2])) << 1;
        end
      end else if (j < 2 * NC + N % 3) begin : g_pass
        assign w_out[j] = w_in[3*NC + j - 2*NC];
      end else begin : g_zero
        assign w_out[j] = '0;
      end
    end
  end

  // Elastic stage registers. A stage loads when empty or when its current
  // contents leave this cycle; ready is chained back from the tail.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LE = (((k + 1) * REG_EVERY < LEVELS) ? (k + 1) * REG_EVERY : LEVELS) - 1;
    logic [OUT_WIDTH-1:0] r_data [PP_NUM];
    logic [TAG_W-1:0]     r_tag;
    logic                 r_v;
    logic                 w_dn_rdy;
    logic                 w_ld;
    logic                 w_up_v;
    logic [TAG_W-1:0]     w_up_tag;

    if (k == STAGES - 1) begin : g_last
      assign w_dn_rdy = w_tail_rdy;
    end else begin : g_mid
      assign w_dn_rdy = g_stg[k+1].w_ld;
    end
    assign w_ld = !r_v | w_dn_rdy;

    if (k == 0) begin : g_first
      assign w_up_v   = in_valid & in_ready;
      assign w_up_tag = in_tag;
    end else begin : g_next
      assign w_up_v   = g_stg[k-1].r_v;
      assign w_up_tag = g_stg[k-1].r_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_tag <= '0;
        for (int j = 0; j < PP_NUM; j++) r_data[j] <= '0;
      end else begin
        if (flush)     r_v <= 1'b0;
        else if (w_ld) r_v <= w_up_v;
        // Payload may load while empty; only the valid bit carries meaning.
        if (w_ld) begin
          r_tag <= w_up_tag;
          for (int j = 0; j < PP_NUM; j++) r_data[j] <= g_lvl[LE].w_out[j];
        end
      end
    end
  end

  assign in_ready = g_stg[0].w_ld & !flush;

`ifdef CSA_TREE_CPA_EN
  logic                 r_cv;
  logic [OUT_WIDTH-1:0] r_csum;
  logic [OUT_WIDTH-1:0] r_ccarry;
  logic [OUT_WIDTH-1:0] r_cprod;
  logic [TAG_W-1:0]     r_ctag;

  assign w_tail_rdy = !r_cv | out_ready;

  // Final carry-propagate stage; the redundant pair travels alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cv     <= 1'b0;
      r_csum   <= '0;
      r_ccarry <= '0;
      r_cprod  <= '0;
      r_ctag   <= '0;
    end else begin
      if (flush)           r_cv <= 1'b0;
      else if (w_tail_rdy) r_cv <= g_stg[STAGES-1].r_v;
      if (w_tail_rdy) begin
        r_csum   <= g_stg[STAGES-1].r_data[0];
        r_ccarry <= g_stg[STAGES-1].r_data[1];
        r_cprod  <= g_stg[STAGES-1].r_data[0] + g_stg[STAGES-1].r_data[1];
        r_ctag   <= g_stg[STAGES-1].r_tag;
      end
    end
  end

  assign out_valid   = r_cv;
  assign out_sum     = r_csum;
  assign out_carry   = r_ccarry;
  assign out_product = r_cprod;
  assign out_tag     = r_ctag;
`else
  assign w_tail_rdy = out_ready;
  assign out_valid  = g_stg[STAGES-1].r_v;
  assign out_sum    = g_stg[STAGES-1].r_data[0];
  assign out_carry  = g_stg[STAGES-1].r_data[1];
  assign out_tag    = g_stg[STAGES-1].r_tag;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Scoreboard bench for csa_tree_pipe at the default FP32 configuration
// (13 x 26-bit pps, shift 2, 52-bit result, one level per stage).
module tb_csa_tree_pipe;
  localparam int unsigned PPN = 13;
  localparam int unsigned PPW = 26;
  localparam int unsigned OW  = 52;
  localparam int unsigned TW  = 4;
`ifdef CSA_TREE_CPA_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [PPN*PPW-1:0] in_pp = '0;
  logic [TW-1:0]      in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [OW-1:0]      out_sum;
  logic [OW-1:0]      out_carry;
  logic [TW-1:0]      out_tag;
`ifdef CSA_TREE_CPA_EN
  logic [OW-1:0]      out_product;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [OW-1:0] val;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  csa_tree_pipe #(
    .PP_NUM(PPN), .PP_WIDTH(PPW), .PP_SHIFT(2), .OUT_WIDTH(OW), .REG_EVERY(1), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag)
`ifdef CSA_TREE_CPA_EN
    , .out_product(out_product)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Golden value: plain sum of weighted, sign-extended pps.
  function automatic logic [OW-1:0] model(input logic [PPN*PPW-1:0] v);
    logic [OW-1:0] acc;
    acc = '0;
    for (int i = 0; i < PPN; i++) acc += OW'($signed(v[i*PPW +: PPW])) << (i * 2);
    return acc;
  endfunction

  function automatic logic [PPN*PPW-1:0] rand_pp();
    logic [PPN*PPW-1:0] v;
    for (int i = 0; i < PPN; i++) v[i*PPW +: PPW] = PPW'($urandom);
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [PPN*PPW-1:0] pp, input logic [TW-1:0] tag, input logic [OW-1:0] e_val);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pp    = pp;
    in_tag   = tag;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b for tag %h", in_ready, tag);
    end else begin
      q.push_back(exp_t'({tag, e_val}));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_lat();
    int lat;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compare every delivered beat, and the held beat during stalls.
  initial begin
    exp_t          e;
    logic [OW-1:0] s;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        s = out_sum + out_carry;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %h value %h expected no beat", out_tag, s);
        end else if (!out_ready) begin
          chk("stall_hold_val", 64'(s), 64'(q[0].val));
          chk("stall_hold_tag", 64'(out_tag), 64'(q[0].tag));
        end else begin
          e = q.pop_front();
          chk("result", 64'(s), 64'(e.val));
          chk("tag", 64'(out_tag), 64'(e.tag));
`ifdef CSA_TREE_CPA_EN
          chk("product", 64'(out_product), 64'(e.val));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d beats pending", q.size());
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PPN*PPW-1:0] v;

    // Reset state.
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_carry", 64'(out_carry), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Single beat, first-beat latency.
    v = '0;
    v[0 +: PPW] = 26'd1;
    send(v, 4'd3, 52'd1);
    check_lat();
    drain();

    // Directed corner vectors, back to back.
    v = '1;
    send(v, 4'd4, 52'hFFFFFFEAAAAAB);
    v = '0;
    v[12*PPW +: PPW] = 26'd1;
    send(v, 4'd5, 52'h0000001000000);
    v = '0;
    v[1*PPW +: PPW] = 26'd3;
    v[2*PPW +: PPW] = 26'h3FFFFFF;
    send(v, 4'd6, 52'hFFFFFFFFFFFFC);
    v = '0;
    v[12*PPW +: PPW] = 26'h2000000;
    send(v, 4'd7, 52'hE000000000000);
    v = '0;
    v[0 +: PPW] = 26'h1FFFFFF;
    send(v, 4'd8, 52'h0000001FFFFFF);
    drain();

    // Continuous stream with a downstream stall window.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          v = rand_pp();
          send(v, TW'(i), model(v));
        end
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_in_flight", 64'(q.size()), 64'(LAT));
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = rand_pp();
      send(v, TW'(i + 1), model(v));
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    chk("midrst_out_carry", 64'(out_carry), 64'd0);
    chk("midrst_out_tag", 64'(out_tag), 64'd0);
`ifdef CSA_TREE_CPA_EN
    chk("midrst_out_product", 64'(out_product), 64'd0);
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    v = '0;
    v[0 +: PPW] = 26'd5;
    send(v, 4'd9, 52'd5);
    check_lat();
    drain();

    // Flush with beats in flight and a beat offered in the flush cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = rand_pp();
      send(v, TW'(i + 11), model(v));
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pp    = rand_pp();
    in_tag   = 4'hF;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    v = '0;
    v[2*PPW +: PPW] = 26'd1;
    send(v, 4'd10, 52'd16);
    check_lat();
    drain();

    // Random stream against random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          v = rand_pp();
          send(v, TW'(i), model(v));
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
